gray_frame_packetizer: RTL and testbench

- Sits between the camera gray-pixel output and the Sync_245_Controller transmit input.
- Wraps each camera frame in a sync header and a status trailer so the host can find frame boundaries in the byte stream.
- Buffers pixels in a small FIFO so that FTDI backpressure does not silently drop pixels.
- Flags overflow when pixels are lost; all inputs are already synchronized to sys_clk.

---
 rtl/gray_frame_packetizer.sv | 189 ++++++++++++++++++
 tb/tb_gray_frame_packetizer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_packetizer.sv
// Frames camera gray pixels as: sync header, FIFO-buffered pixels, status trailer.
// Drives a byte stream with a valid/ready handshake toward the Sync_245 transmit side.
module gray_frame_packetizer #(
    parameter int FIFO_AW    = 4,
    parameter int FRAME_ID_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  stream_en,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic [7:0]            pixel_in,
    input  logic                  pixel_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  overflow,
    output logic [FRAME_ID_W-1:0] frames_sent,
    output logic [2:0]            pk_state
);

    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PIXELS  = 3'd2,
        TRAILER = 3'd3
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               frame_active;
    logic               end_pending;
    logic               frame_ovf;
    logic [2:0]         byte_idx;

    logic               fifo_full;
    logic               fifo_empty;
    logic               slot_free;
    logic               wr_en;
    logic               pop;
    logic [7:0]         wr_byte;
    logic [7:0]         hdr_byte;
    logic [7:0]         trl_byte;

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign slot_free  = !tx_valid || tx_ready;
    assign wr_en      = frame_active && pixel_valid && !fifo_full;
    assign pop        = (state == PIXELS) && slot_free && !fifo_empty;
    assign wr_byte    = (pixel_in == 8'hFF) ? 8'hFE : pixel_in;
    assign pk_state   = state;

    always_comb begin
        hdr_byte = 8'h00;
        trl_byte = 8'h00;
        case (byte_idx[1:0])
            2'd0: begin
                hdr_byte = 8'hFF;
                trl_byte = 8'hFF;
            end
            2'd1: begin
                hdr_byte = 8'h00;
                trl_byte = 8'h00;
            end
            2'd2: begin
                hdr_byte = 8'hA5;
                trl_byte = 8'h5A;
            end
            default: begin
                hdr_byte = 8'(frames_sent);
                trl_byte = {7'b0, frame_ovf};
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_active <= 1'b0;
            end_pending  <= 1'b0;
            frame_ovf    <= 1'b0;
            overflow     <= 1'b0;
            frames_sent  <= '0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            byte_idx     <= 3'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (frame_active && pixel_valid && fifo_full) begin
                frame_ovf <= 1'b1;
                overflow  <= 1'b1;
            end

            // A pixel on the same cycle as frame_end was already captured above.
            if (frame_active && frame_end) begin
                end_pending  <= 1'b1;
                frame_active <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (stream_en && frame_start) begin
                        frame_ovf    <= 1'b0;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        count        <= '0;
                        frame_active <= 1'b1;
                        byte_idx     <= 3'd0;
                        state        <= HEADER;
                    end
                end
                HEADER: begin
                    if (slot_free) begin
                        if (byte_idx != 3'd4) begin
                            tx_data  <= hdr_byte;
                            tx_valid <= 1'b1;
                            byte_idx <= byte_idx + 3'd1;
                        end else begin
                            tx_valid <= 1'b0;
                            byte_idx <= 3'd0;
                            state    <= PIXELS;
                        end
                    end
                end
                PIXELS: begin
                    if (slot_free) begin
                        if (!fifo_empty) begin
                            tx_data  <= mem[rd_ptr];
                            tx_valid <= 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                            if (end_pending) begin
                                byte_idx <= 3'd0;
                                state    <= TRAILER;
                            end
                        end
                    end
                end
                TRAILER: begin
                    // byte_idx==4 with a free slot means the status byte was just accepted.
                    if (slot_free) begin
                        if (byte_idx != 3'd4) begin
                            tx_data  <= trl_byte;
                            tx_valid <= 1'b1;
                            byte_idx <= byte_idx + 3'd1;
                        end else begin
                            tx_valid    <= 1'b0;
                            byte_idx    <= 3'd0;
                            frames_sent <= frames_sent + FRAME_ID_W'(1);
                            end_pending <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_frame_packetizer.sv
// Bench for gray_frame_packetizer: queue-based behavioural model checked every cycle,
// plus literal byte streams for the directed frames and randomized frames afterwards.
module tb_gray_frame_packetizer;

    localparam int DEPTH = 16;

    typedef logic [7:0] bytes_t[$];

    logic       sys_clk;
    logic       reset;
    logic       stream_en;
    logic       frame_start;
    logic       frame_end;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       overflow;
    logic [7:0] frames_sent;
    logic [2:0] pk_state;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking = 0;

    gray_frame_packetizer #(.FIFO_AW(4), .FRAME_ID_W(8)) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .stream_en(stream_en),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .overflow(overflow),
        .frames_sent(frames_sent),
        .pk_state(pk_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural model: phase number, pixel queue, and a queue of framing bytes still to emit.
    int         m_phase;
    logic [7:0] m_fifo[$];
    logic [7:0] m_seq[$];
    bit         m_active, m_end, m_fovf, m_ovf, m_txv, m_rst_edge;
    logic [7:0] m_txd, m_frames;
    bit         m_slot, m_take, m_fe;
    int         m_occ;

    always @(posedge sys_clk) begin
        m_rst_edge = reset;
        if (reset) begin
            m_phase = 0; m_fifo.delete(); m_seq.delete();
            m_active = 0; m_end = 0; m_fovf = 0; m_ovf = 0;
            m_txv = 0; m_txd = 8'h00; m_frames = 8'h00;
        end else begin
            m_slot = !m_txv || tx_ready;
            m_occ  = m_fifo.size();
            m_take = m_active && pixel_valid;
            m_fe   = m_active && frame_end;
            case (m_phase)
                0: if (stream_en && frame_start) begin
                    m_fifo.delete(); m_fovf = 0; m_active = 1;
                    m_seq = '{8'hFF, 8'h00, 8'hA5, m_frames};
                    m_phase = 1;
                end
                1: if (m_slot) begin
                    if (m_seq.size() > 0) begin m_txd = m_seq.pop_front(); m_txv = 1; end
                    else begin m_txv = 0; m_phase = 2; end
                end
                2: if (m_slot) begin
                    if (m_occ > 0) begin m_txd = m_fifo.pop_front(); m_txv = 1; end
                    else begin
                        m_txv = 0;
                        if (m_end) begin
                            m_phase = 3;
                            m_seq = '{8'hFF, 8'h00, 8'h5A, {7'b0, m_fovf}};
                        end
                    end
                end
                default: if (m_slot) begin
                    if (m_seq.size() > 0) begin m_txd = m_seq.pop_front(); m_txv = 1; end
                    else begin m_txv = 0; m_frames = m_frames + 8'd1; m_end = 0; m_phase = 0; end
                end
            endcase
            if (m_take) begin
                if (m_occ >= DEPTH) begin m_fovf = 1; m_ovf = 1; end
                else m_fifo.push_back(pixel_in == 8'hFF ? 8'hFE : pixel_in);
            end
            if (m_fe) begin m_end = 1; m_active = 0; end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    bytes_t got;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge sys_clk) begin
        if (checking) begin
            checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, m_txv});
            checkOutput("tx_data", {24'b0, tx_data}, {24'b0, m_txd});
            checkOutput("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            checkOutput("frames_sent", {24'b0, frames_sent}, {24'b0, m_frames});
            checkOutput("pk_state", {29'b0, pk_state}, m_phase);
            if (prev_stall && !m_rst_edge) begin
                checkOutput("stall_valid", {31'b0, tx_valid}, 32'd1);
                checkOutput("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready && !reset) got.push_back(tx_data);
        end
    end

    task automatic applyStimulus(input bit fs, input bit fe, input bit pv, input logic [7:0] px);
        frame_start = fs;
        frame_end   = fe;
        pixel_valid = pv;
        pixel_in    = px;
        @(posedge sys_clk);
        #2;
    endtask

    task automatic waitIdle(input int budget, input bit rand_ready);
        int n = 0;
        while (pk_state != 3'd0 && n < budget) begin
            if (rand_ready) tx_ready = ($urandom % 3) != 0;
            applyStimulus(0, 0, 0, 8'h00);
            n++;
        end
        checkOutput("wait_idle", {29'b0, pk_state}, 32'd0);
        tx_ready = 1'b1;
        applyStimulus(0, 0, 0, 8'h00);
    endtask

    task automatic compareStream(input string name, input bytes_t exp);
        checkOutput($sformatf("%s_len", name), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            checkOutput($sformatf("%s_b%0d", name, i), {24'b0, got[i]}, {24'b0, exp[i]});
        got.delete();
    endtask

    initial begin
        bytes_t exp;
        logic [7:0] px;
        reset = 1; stream_en = 0; tx_ready = 1;
        repeat (3) applyStimulus(0, 0, 0, 8'h00);
        reset = 0;
        checking = 1;
        checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("rst_tx_data", {24'b0, tx_data}, 32'd0);
        checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst_frames", {24'b0, frames_sent}, 32'd0);
        checkOutput("rst_state", {29'b0, pk_state}, 32'd0);

        // Basic frame of three pixels.
        stream_en = 1; got.delete();
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h10);
        applyStimulus(0, 0, 1, 8'h20);
        applyStimulus(0, 0, 1, 8'h30);
        applyStimulus(0, 1, 0, 8'h00);
        waitIdle(200, 0);
        compareStream("t1", '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h00, 8'h5A, 8'h00});
        checkOutput("t1_frames", {24'b0, frames_sent}, 32'd1);

        // Clamp of 0xFF, frame id 1; the last pixel shares its cycle with frame_end.
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'hFF);
        applyStimulus(0, 1, 1, 8'h01);
        waitIdle(200, 0);
        compareStream("t2", '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'hFE, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h00});

        // Full stall: 16 kept, 4 dropped, status 1, then a clean frame with status 0.
        tx_ready = 0;
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 1; i <= 20; i++) applyStimulus(0, 0, 1, 8'(i));
        applyStimulus(0, 1, 0, 8'h00);
        repeat (3) applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t3_overflow", {31'b0, overflow}, 32'd1);
        tx_ready = 1;
        waitIdle(200, 0);
        exp = '{8'hFF, 8'h00, 8'hA5, 8'h02};
        for (int i = 1; i <= 16; i++) exp.push_back(8'(i));
        exp.push_back(8'hFF); exp.push_back(8'h00); exp.push_back(8'h5A); exp.push_back(8'h01);
        compareStream("t3", exp);
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h77);
        applyStimulus(0, 1, 0, 8'h00);
        waitIdle(200, 0);
        compareStream("t3b", '{8'hFF, 8'h00, 8'hA5, 8'h03, 8'h77, 8'hFF, 8'h00, 8'h5A, 8'h00});
        checkOutput("t3b_overflow", {31'b0, overflow}, 32'd1);

        // tx_ready toggling every cycle.
        exp = '{8'hFF, 8'h00, 8'hA5, 8'h04};
        tx_ready = 0;
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            px = 8'($urandom);
            exp.push_back(px == 8'hFF ? 8'hFE : px);
            tx_ready = ~tx_ready;
            applyStimulus(0, 0, 1, px);
        end
        tx_ready = ~tx_ready;
        applyStimulus(0, 1, 0, 8'h00);
        for (int i = 0; i < 60 && pk_state != 3'd0; i++) begin
            tx_ready = ~tx_ready;
            applyStimulus(0, 0, 0, 8'h00);
        end
        waitIdle(50, 0);
        exp.push_back(8'hFF); exp.push_back(8'h00); exp.push_back(8'h5A); exp.push_back(8'h00);
        compareStream("t4", exp);

        // stream_en low in IDLE ignores everything; dropping it mid-frame does not truncate.
        stream_en = 0;
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h55);
        applyStimulus(0, 1, 1, 8'h66);
        repeat (3) applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t5_idle", {29'b0, pk_state}, 32'd0);
        checkOutput("t5_quiet", got.size(), 32'd0);
        stream_en = 1;
        applyStimulus(1, 0, 0, 8'h00);
        stream_en = 0;
        applyStimulus(0, 0, 1, 8'h33);
        applyStimulus(0, 0, 1, 8'h44);
        applyStimulus(0, 1, 0, 8'h00);
        waitIdle(200, 0);
        compareStream("t5", '{8'hFF, 8'h00, 8'hA5, 8'h05, 8'h33, 8'h44, 8'hFF, 8'h00, 8'h5A, 8'h00});
        applyStimulus(1, 0, 0, 8'h00);
        repeat (2) applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t5_hold", {29'b0, pk_state}, 32'd0);
        checkOutput("t5_frames", {24'b0, frames_sent}, 32'd6);

        // Reset while bytes are queued in PIXELS.
        stream_en = 1; tx_ready = 1;
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 20 && pk_state != 3'd2; i++) applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t6_in_pixels", {29'b0, pk_state}, 32'd2);
        tx_ready = 0;
        for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i));
        applyStimulus(0, 0, 0, 8'h00);
        reset = 1;
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t6_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("t6_state", {29'b0, pk_state}, 32'd0);
        checkOutput("t6_frames", {24'b0, frames_sent}, 32'd0);
        reset = 0; tx_ready = 1;
        applyStimulus(0, 0, 0, 8'h00);
        got.delete();
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 8'h00);
        waitIdle(200, 0);
        compareStream("t6", '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'h5A, 8'h00});

        // Randomized frames checked against the model every cycle.
        for (int f = 0; f < 12; f++) begin
            int len = $urandom_range(0, 30);
            int rdy_pct = $urandom_range(10, 100);
            stream_en = 1;
            tx_ready = ($urandom_range(1, 100) <= rdy_pct);
            applyStimulus(1, 0, 0, 8'h00);
            for (int k = 0; k < len; k++) begin
                tx_ready = ($urandom_range(1, 100) <= rdy_pct);
                if ($urandom % 10 == 0) stream_en = 0;
                px = ($urandom % 6 == 0) ? 8'hFF : 8'($urandom);
                applyStimulus(($urandom % 12) == 0, 0, ($urandom % 4) != 0, px);
            end
            applyStimulus(0, 1, ($urandom % 2) == 1, 8'($urandom));
            waitIdle(600, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
